// File: rtl/prim_secded_pkg.sv
// Shared constants and helpers for the inverted Hsiao SECDED(64,57) encoder and decoder.
package prim_secded_pkg;

    localparam int unsigned SecdedN = 64;
    localparam int unsigned SecdedK = 57;
    localparam int unsigned SecdedM = 7;

    // Fixed pattern XORed onto stored codewords so all-zero and all-one words are never valid
    localparam logic [SecdedN-1:0] SecdedInv = 64'h5400000000000000;

    // Data-bit participation masks for each syndrome bit; check bit 57+k is added separately
    localparam logic [SecdedN-1:0] SynMask [SecdedM] = '{
        64'h0103fff800007fff,
        64'h017c1ff801ff801f,
        64'h01bde1f87e0781e1,
        64'h01deee3b8e388e22,
        64'h01ef76cdb2c93244,
        64'h01f7bb56d5525488,
        64'h01fbdda769a46910
    };

    // Syndrome of an already de-inverted codeword
    function automatic logic [SecdedM-1:0] secded_syndrome(input logic [SecdedN-1:0] cw);
        logic [SecdedM-1:0] syn;
        syn = '0;
        for (int k = 0; k < int'(SecdedM); k++) begin
            syn[3'(k)] = ^(cw & (SynMask[3'(k)] | (64'd1 << (SecdedK + 32'(k)))));
        end
        return syn;
    endfunction

    // H-matrix column for codeword bit idx (data bits first, then unit vectors for check bits)
    function automatic logic [SecdedM-1:0] secded_h_column(input logic [5:0] idx);
        logic [SecdedM-1:0] col;
        col = '0;
        if (idx < 6'd57) begin
            for (int k = 0; k < int'(SecdedM); k++) begin
                col[3'(k)] = SynMask[3'(k)][idx];
            end
        end else begin
            col = 7'd1 << (idx - 6'd57);
        end
        return col;
    endfunction

endpackage

// File: rtl/prim_secded_inv_64_57_dec_pipe_if.sv
// Valid/ready streaming bus between a codeword source and the decoder pipeline.
interface prim_secded_inv_64_57_dec_pipe_if;
    import prim_secded_pkg::*;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [SecdedN-1:0]     in_data_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [SecdedK-1:0]     out_data_o;
    logic [SecdedM-1:0]     out_syndrome_o;
    logic [1:0]             out_err_o;

    // Source / sink side
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_syndrome_o, out_err_o
    );

    // Decoder side
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_syndrome_o, out_err_o
    );

endinterface

// File: rtl/prim_secded_inv_64_57_dec.sv
// Combinational correct/classify core: flips the data bit whose H column matches the syndrome.
module prim_secded_inv_64_57_dec
    import prim_secded_pkg::*;
(
    input  logic [SecdedK-1:0] cw_data,
    input  logic [SecdedM-1:0] syndrome,
    output logic [SecdedK-1:0] data_c,
    output logic [1:0]         err_c
);

    // Correction: an odd syndrome that matches no column leaves the data untouched
    always_comb begin
        data_c = cw_data;
        for (int i = 0; i < int'(SecdedK); i++) begin
            data_c[6'(i)] = cw_data[6'(i)] ^ (syndrome == secded_h_column(6'(i)));
        end
    end

    // Classification: odd weight is single, nonzero even weight is double
    always_comb begin
        err_c    = '0;
        err_c[0] = ^syndrome;
        err_c[1] = (syndrome != '0) & ~(^syndrome);
    end

endmodule

// File: rtl/prim_secded_inv_64_57_dec_pipe.sv
// Two-stage elastic SECDED(64,57) inverted decoder with saturating error counters and
// a sticky first-error syndrome capture.
module prim_secded_inv_64_57_dec_pipe
    import prim_secded_pkg::*;
#(
    parameter int unsigned CntW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    prim_secded_inv_64_57_dec_pipe_if.slave bus,
    input  logic                        cnt_clr_i,
    output logic [CntW-1:0]             single_cnt_o,
    output logic [CntW-1:0]             double_cnt_o,
    output logic                        first_syn_valid_o,
    output logic [SecdedM-1:0]          first_syn_o
);

    localparam logic [CntW-1:0] CntMax = '1;

    logic [SecdedN-1:0] cw_c;
    logic [SecdedM-1:0] syn_c;
    logic               s1_load_c;
    logic               s2_load_c;
    logic               xfer_c;

    logic               s1_valid_q;
    logic [SecdedK-1:0] s1_data_q;
    logic [SecdedM-1:0] s1_syn_q;

    logic               s2_valid_q;
    logic [SecdedK-1:0] s2_data_q;
    logic [SecdedM-1:0] s2_syn_q;
    logic [1:0]         s2_err_q;

    logic [SecdedK-1:0] corr_data_c;
    logic [1:0]         corr_err_c;

    logic [CntW-1:0]    single_cnt_q;
    logic [CntW-1:0]    double_cnt_q;
    logic               first_valid_q;
    logic [SecdedM-1:0] first_syn_q;

    // Remove the inversion and compute the syndrome ahead of stage 1
    always_comb begin
        cw_c  = bus.in_data_i ^ SecdedInv;
        syn_c = secded_syndrome(cw_c);
    end

    // Elastic load conditions; stage 1 refills in the same cycle stage 2 drains
    always_comb begin
        s2_load_c = ~s2_valid_q | bus.out_ready_i;
        s1_load_c = ~s1_valid_q | s2_load_c;
        xfer_c    = s2_valid_q & bus.out_ready_i;
    end

    assign bus.in_ready_o = s1_load_c;

    prim_secded_inv_64_57_dec u_core (
        .cw_data  (s1_data_q),
        .syndrome (s1_syn_q),
        .data_c   (corr_data_c),
        .err_c    (corr_err_c)
    );

    // Pipeline registers; payload only moves when a valid word advances
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_err_q   <= '0;
        end else begin
            if (s1_load_c) begin
                s1_valid_q <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    s1_data_q <= cw_c[SecdedK-1:0];
                    s1_syn_q  <= syn_c;
                end
            end
            if (s2_load_c) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= corr_data_c;
                    s2_syn_q  <= s1_syn_q;
                    s2_err_q  <= corr_err_c;
                end
            end
        end
    end

    assign bus.out_valid_o    = s2_valid_q;
    assign bus.out_data_o     = s2_data_q;
    assign bus.out_syndrome_o = s2_syn_q;
    assign bus.out_err_o      = s2_err_q;

    // Status counters and first-error capture; clear wins over a same-cycle event
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            single_cnt_q  <= '0;
            double_cnt_q  <= '0;
            first_valid_q <= 1'b0;
            first_syn_q   <= '0;
        end else if (xfer_c) begin
            if (s2_err_q[0] && (single_cnt_q != CntMax)) begin
                single_cnt_q <= single_cnt_q + CntW'(1);
            end
            if (s2_err_q[1] && (double_cnt_q != CntMax)) begin
                double_cnt_q <= double_cnt_q + CntW'(1);
            end
            if (!first_valid_q && (s2_syn_q != '0)) begin
                first_valid_q <= 1'b1;
                first_syn_q   <= s2_syn_q;
            end
        end
    end

    assign single_cnt_o      = single_cnt_q;
    assign double_cnt_o      = double_cnt_q;
    assign first_syn_valid_o = first_valid_q;
    assign first_syn_o       = first_syn_q;

endmodule

// File: tb/tb_prim_secded_inv_64_57_dec_pipe.sv
// Directed bench for the pipelined inverted SECDED(64,57) decoder (counters narrowed to 2 bits).
module tb_prim_secded_inv_64_57_dec_pipe;

    localparam int unsigned CntW = 2;

    logic            clk;
    logic            rst;
    logic            cnt_clr;
    logic [CntW-1:0] single_cnt;
    logic [CntW-1:0] double_cnt;
    logic            first_syn_valid;
    logic [6:0]      first_syn;

    int checks;
    int failures;

    prim_secded_inv_64_57_dec_pipe_if bus ();

    prim_secded_inv_64_57_dec_pipe #(.CntW(CntW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (bus),
        .cnt_clr_i         (cnt_clr),
        .single_cnt_o      (single_cnt),
        .double_cnt_o      (double_cnt),
        .first_syn_valid_o (first_syn_valid),
        .first_syn_o       (first_syn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus table with hand-derived decode results
    logic [63:0] tab_in   [10];
    logic [56:0] tab_data [10];
    logic [6:0]  tab_syn  [10];
    logic [1:0]  tab_err  [10];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle (pipeline assumed able to accept)
    task automatic send_one(input logic [63:0] w);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = w;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    // Wait a bounded number of cycles for out_valid
    task automatic wait_out(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (bus.out_valid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic chk_out(input string tag, input logic [56:0] d, input logic [6:0] s, input logic [1:0] e);
        chk({tag, "_data"}, 64'(bus.out_data_o), 64'(d));
        chk({tag, "_syn"},  64'(bus.out_syndrome_o), 64'(s));
        chk({tag, "_err"},  64'(bus.out_err_o), 64'(e));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tab_in[0] = 64'h5400000000000000; tab_data[0] = 57'h0; tab_syn[0] = 7'h00; tab_err[0] = 2'b00;
        tab_in[1] = 64'h5400000000000001; tab_data[1] = 57'h0; tab_syn[1] = 7'h07; tab_err[1] = 2'b01;
        tab_in[2] = 64'h5400000000000002; tab_data[2] = 57'h0; tab_syn[2] = 7'h0B; tab_err[2] = 2'b01;
        tab_in[3] = 64'h5400000000000003; tab_data[3] = 57'h3; tab_syn[3] = 7'h0C; tab_err[3] = 2'b10;
        tab_in[4] = 64'h5600000000000000; tab_data[4] = 57'h0; tab_syn[4] = 7'h01; tab_err[4] = 2'b01;
        tab_in[5] = 64'h5500000000000000; tab_data[5] = 57'h0; tab_syn[5] = 7'h7F; tab_err[5] = 2'b01;
        tab_in[6] = 64'h5000000000000000; tab_data[6] = 57'h0; tab_syn[6] = 7'h02; tab_err[6] = 2'b01;
        tab_in[7] = 64'hD400000000000000; tab_data[7] = 57'h0; tab_syn[7] = 7'h40; tab_err[7] = 2'b01;
        tab_in[8] = 64'h5200000000000000; tab_data[8] = 57'h0; tab_syn[8] = 7'h03; tab_err[8] = 2'b10;
        tab_in[9] = 64'h5400000000000004; tab_data[9] = 57'h0; tab_syn[9] = 7'h13; tab_err[9] = 2'b01;

        rst             = 1'b1;
        cnt_clr         = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        step(); step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk_out("rst", 57'h0, 7'h00, 2'b00);
        chk("rst_single", 64'(single_cnt), 64'd0);
        chk("rst_double", 64'(double_cnt), 64'd0);
        chk("rst_fsv", 64'(first_syn_valid), 64'd0);
        chk("rst_fs", 64'(first_syn), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Clean word
        send_one(64'h5400000000000000);
        wait_out("clean_lat");
        chk_out("clean", 57'h0, 7'h00, 2'b00);
        step();
        chk("clean_single", 64'(single_cnt), 64'd0);
        chk("clean_double", 64'(double_cnt), 64'd0);
        chk("clean_fsv", 64'(first_syn_valid), 64'd0);
        chk("clean_ovalid", 64'(bus.out_valid_o), 64'd0);

        // Single data-bit error
        send_one(64'h5400000000000001);
        wait_out("single_lat");
        chk_out("single", 57'h0, 7'h07, 2'b01);
        step();
        chk("single_cnt", 64'(single_cnt), 64'd1);
        chk("single_fsv", 64'(first_syn_valid), 64'd1);
        chk("single_fs", 64'(first_syn), 64'h07);

        // Double error leaves data uncorrected and keeps the sticky syndrome
        send_one(64'h5400000000000003);
        wait_out("double_lat");
        chk_out("double", 57'h3, 7'h0C, 2'b10);
        step();
        chk("double_cnt", 64'(double_cnt), 64'd1);
        chk("double_single", 64'(single_cnt), 64'd1);
        chk("double_fs", 64'(first_syn), 64'h07);

        // Check-bit 57 error
        send_one(64'h5600000000000000);
        wait_out("chk57_lat");
        chk_out("chk57", 57'h0, 7'h01, 2'b01);
        step();
        chk("chk57_single", 64'(single_cnt), 64'd2);

        // Top data bit 56 (all-ones column)
        send_one(64'h5500000000000000);
        wait_out("bit56_lat");
        chk_out("bit56", 57'h0, 7'h7F, 2'b01);
        step();
        chk("bit56_single", 64'(single_cnt), 64'd3);

        // Idle clear
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_single", 64'(single_cnt), 64'd0);
        chk("clr_double", 64'(double_cnt), 64'd0);
        chk("clr_fsv", 64'(first_syn_valid), 64'd0);
        chk("clr_fs", 64'(first_syn), 64'd0);

        // Saturation: five singles into a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send_one(64'h5400000000000001);
            wait_out("sat_lat");
            step();
        end
        chk("sat_single", 64'(single_cnt), 64'd3);
        chk("sat_double", 64'(double_cnt), 64'd0);
        chk("sat_fs", 64'(first_syn), 64'h07);

        // Clear coinciding with a single-error transfer
        send_one(64'h5400000000000001);
        wait_out("clrx_lat");
        chk("clrx_syn", 64'(bus.out_syndrome_o), 64'h07);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clrx_single", 64'(single_cnt), 64'd0);
        chk("clrx_fsv", 64'(first_syn_valid), 64'd0);
        chk("clrx_fs", 64'(first_syn), 64'd0);

        // Fresh capture after clear
        send_one(64'h5400000000000002);
        wait_out("recap_lat");
        chk_out("recap", 57'h0, 7'h0B, 2'b01);
        step();
        chk("recap_single", 64'(single_cnt), 64'd1);
        chk("recap_fsv", 64'(first_syn_valid), 64'd1);
        chk("recap_fs", 64'(first_syn), 64'h0B);

        // Backpressure stream: random out_ready, order and stability checked
        fork
            begin : producer
                logic ok;
                for (int i = 0; i < 10; i++) begin
                    bus.in_valid_i = 1'b1;
                    bus.in_data_i  = tab_in[i];
                    ok = 1'b0;
                    for (int w = 0; w < 50 && !ok; w++) begin
                        @(negedge clk);
                        ok = bus.in_ready_o;
                        step();
                    end
                    chk("bp_accept", 64'(ok), 64'd1);
                end
                bus.in_valid_i = 1'b0;
            end
            begin : consumer
                int          cnt;
                logic        held;
                logic [56:0] h_data;
                logic [6:0]  h_syn;
                logic [1:0]  h_err;
                cnt  = 0;
                held = 1'b0;
                for (int c = 0; c < 400 && cnt < 10; c++) begin
                    step();
                    bus.out_ready_i = 1'(($urandom_range(0, 2) != 0));
                    @(negedge clk);
                    if (held) begin
                        chk("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
                        chk_out("bp_hold", h_data, h_syn, h_err);
                    end
                    held = 1'b0;
                    if (bus.out_valid_o === 1'b1) begin
                        if (bus.out_ready_i) begin
                            chk_out("bp_word", tab_data[cnt], tab_syn[cnt], tab_err[cnt]);
                            cnt++;
                        end else begin
                            held   = 1'b1;
                            h_data = bus.out_data_o;
                            h_syn  = bus.out_syndrome_o;
                            h_err  = bus.out_err_o;
                        end
                    end
                end
                chk("bp_count", 64'(cnt), 64'd10);
            end
        join
        step();
        bus.out_ready_i = 1'b1;
        step(); step();
        chk("bp_drained", 64'(bus.out_valid_o), 64'd0);

        // Full throughput with out_ready held high
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                bus.in_valid_i = 1'b1;
                bus.in_data_i  = tab_in[c];
            end else begin
                bus.in_valid_i = 1'b0;
            end
            @(negedge clk);
            if (c < 6) chk("tp_in_ready", 64'(bus.in_ready_o), 64'd1);
            if (c >= 2) begin
                chk("tp_out_valid", 64'(bus.out_valid_o), 64'd1);
                chk("tp_syn", 64'(bus.out_syndrome_o), 64'(tab_syn[c-2]));
            end
            step();
        end
        chk("tp_empty", 64'(bus.out_valid_o), 64'd0);

        // Reset mid-stream with a stalled, full pipeline
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 64'h5400000000000001;
        step(); step(); step();
        chk("mid_full_valid", 64'(bus.out_valid_o), 64'd1);
        chk("mid_full_ready", 64'(bus.in_ready_o), 64'd0);
        rst = 1'b1;
        step();
        rst             = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        chk("mid_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready_o), 64'd1);
        chk("mid_rst_syn", 64'(bus.out_syndrome_o), 64'd0);
        chk("mid_rst_single", 64'(single_cnt), 64'd0);
        step();
        chk("mid_after_valid", 64'(bus.out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prim_secded_inv_64_57_dec_pipe.md
Name: prim_secded_inv_64_57_dec_pipe

Overview:
- Pipelined, flow-controlled decoder for the inverted Hsiao SECDED(64,57) code.
- Takes a 64-bit stored codeword, removes the inversion, computes the 7-bit syndrome, corrects single-bit errors and flags double-bit errors.
- Sits on the read path of memories and registers protected by the 64/57 inverted encoder.
- Keeps saturating single-error and double-error counters and a sticky first-error syndrome for the status CSRs.

Parameters:
- CntW, 16, width of each error counter.
- Inversion constant, fixed, 64'h5400000000000000: the codeword is XORed with this first.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  codeword valid
- in_ready_o  out  1  decoder can accept a codeword
- in_data_i  in  64  stored (inverted) codeword
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- out_data_o  out  57  corrected data
- out_syndrome_o  out  7  syndrome of this word
- out_err_o  out  2  bit0 = single (corrected), bit1 = double (uncorrectable)
- cnt_clr_i  in  1  clear both counters and the sticky capture
- single_cnt_o  out  CntW  single-error count, saturating
- double_cnt_o  out  CntW  double-error count, saturating
- first_syn_valid_o  out  1  sticky: at least one nonzero syndrome seen since clear
- first_syn_o  out  7  syndrome of the first erroneous word since clear

Behaviour:
- Reset (rst_i sampled high at a clock edge): both stage valids = 0; out_valid_o = 0; out_data_o, out_syndrome_o, out_err_o = 0; counters = 0; first_syn_valid_o = 0; first_syn_o = 0. A reset mid-operation discards in-flight words.
- Pre-decode: cw = in_data_i ^ 64'h5400000000000000.
- Syndrome: s[k] = ^(cw & (M[k] | 1<<(57+k))), with masks
  - M0 = 64'h0103fff800007fff, M1 = 64'h017c1ff801ff801f
  - M2 = 64'h01bde1f87e0781e1, M3 = 64'h01deee3b8e388e22
  - M4 = 64'h01ef76cdb2c93244, M5 = 64'h01f7bb56d5525488
  - M6 = 64'h01fbdda769a46910
- H column of data bit i (i < 57) = {M6[i], …, M0[i]}. Column of check bit 57+k = unit vector k.
- Classification:
  - single = ^s (odd weight).
  - double = (s != 0) & ~^s.
  - Corrected data bit i = cw[i] ^ (s == column i).
  - An odd-weight syndrome matching no column is still flagged single; data passes through uncorrected.
- Pipeline, latency 2 cycles:
  - Stage 1 registers cw and s.
  - Stage 2 registers corrected data, syndrome and error flags.
- Elastic handshake:
  - Stage 2 loads when !s2_valid | out_ready_i.
  - Stage 1 loads when !s1_valid | stage-2 load.
  - in_ready_o = stage-1 load condition (combinational path from out_ready_i is permitted).
  - Full throughput of 1 word/cycle when out_ready_i is held high.
  - Out payload is stable while out_valid_o & !out_ready_i.
  - A transfer happens on valid & ready at a clock edge.
- Counters update on the output transfer (out_valid_o & out_ready_i):
  - single_cnt_o += out_err_o[0]; double_cnt_o += out_err_o[1].
  - Each saturates at 2^CntW-1.
- Sticky capture: on the first transfer with a nonzero syndrome while first_syn_valid_o = 0, load first_syn_o and set first_syn_valid_o.
- cnt_clr_i takes priority over a same-cycle increment or capture: the result is 0 and the event in that cycle is not counted.
- cnt_clr_i does not affect the data pipeline.

Decomposition:
- Shared package prim_secded_pkg holds:
  - the 7 mask constants;
  - the inversion constant 64'h5400000000000000;
  - a function computing the syndrome of a 64-bit codeword;
  - a function returning the 7-bit H column for index 0..63.
- The encoder and decoder both use this package.
- One sub-module is natural: prim_secded_inv_64_57_dec, a purely combinational syndrome/correct/classify core.
- prim_secded_inv_64_57_dec_pipe wraps the core with the pipeline registers, counters and capture.

Test Plan:
- Clean word: in 64'h5400000000000000 -> 2 cycles later data 0, syndrome 0, err 2'b00, counters unchanged.
- Single data error: in 64'h5400000000000001 -> data 0, syndrome 7'h07, err 2'b01, single_cnt 1, first_syn 7'h07 and first_syn_valid_o 1.
- Double error: in 64'h5400000000000003 -> syndrome 7'h0C, err 2'b10, double_cnt +1, first_syn unchanged at 7'h07.
- Check-bit error: in 64'h5600000000000000 (bit 57 flipped) -> data 0, syndrome 7'h01, err 2'b01.
- Backpressure:
  - Stimulus: stream 10 words with out_ready_i toggling pseudo-randomly.
  - Response: no loss or duplication, order kept, payload stable while stalled; with out_ready_i held high, 1 word/cycle.
- Saturation and clear:
  - Stimulus: CntW=2, send 5 single-error words.
  - Response: single_cnt 3; then cnt_clr_i coinciding with a single-error transfer -> count 0, sticky capture cleared.
  - Stimulus: assert rst_i mid-stream.
  - Response: out_valid_o 0 on the next cycle.
